// File: rtl/dcache_wt_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Sits between the CPU sram-like data port and the memory-side sram-like port.
module dcache_wt_direct #(
  parameter int unsigned INDEX_WIDTH  = 8,
  parameter int unsigned OFFSET_WIDTH = 2,
  parameter int unsigned TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        no_dcache,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int unsigned NumLines = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StHitRd,
    StMemReq,
    StMemWait
  } state_e;

  state_e state_q, state_d;

  // Line storage; only the valid bits need a reset value.
  logic [NumLines-1:0]  valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [NumLines];
  logic [31:0]          data_q [NumLines];

  // Transaction fields captured at acceptance.
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        nc_q;
  logic        hit_q;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic                   req_hit;
  logic [TAG_WIDTH-1:0]   lat_tag;
  logic [INDEX_WIDTH-1:0] lat_index;
  logic                   accept;
  logic                   line_read;
  logic                   mem_done;
  logic                   fill_en;
  logic                   merge_en;
  logic [3:0]             lane_mask;
  logic [31:0]            merged_word;

  assign req_tag   = cpu_data_addr[31 -: TAG_WIDTH];
  assign req_index = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_hit   = valid_q[req_index] && (tag_q[req_index] == req_tag) && !no_dcache;

  assign lat_tag   = addr_q[31 -: TAG_WIDTH];
  assign lat_index = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];

  assign accept    = (state_q == StIdle) && cpu_data_req && !rst;
  // Cached reads fetch the whole aligned word so the line can be filled.
  assign line_read = !wr_q && !nc_q;
  assign mem_done  = (state_q == StMemWait) && cache_data_data_ok && !rst;
  assign fill_en   = mem_done && line_read;
  assign merge_en  = mem_done && wr_q && !nc_q && hit_q;

  always_comb begin
    lane_mask = 4'b0000;
    case (size_q)
      2'd0:    lane_mask[addr_q[1:0]] = 1'b1;
      2'd1:    lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  always_comb begin
    merged_word = data_q[lat_index];
    for (int b = 0; b < 4; b++) begin
      if (lane_mask[b]) begin
        merged_word[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  // Memory request fields are driven from the latched transaction.
  assign cache_data_wr    = wr_q;
  assign cache_data_size  = line_read ? 2'd2 : size_q;
  assign cache_data_addr  = line_read ? {addr_q[31:2], 2'b00} : addr_q;
  assign cache_data_wdata = wdata_q;

  always_comb begin
    state_d          = state_q;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = '0;
    cache_data_req   = 1'b0;
    case (state_q)
      StIdle: begin
        cpu_data_addr_ok = cpu_data_req;
        if (cpu_data_req) begin
          state_d = (!cpu_data_wr && req_hit) ? StHitRd : StMemReq;
        end
      end
      StHitRd: begin
        cpu_data_data_ok = 1'b1;
        cpu_data_rdata   = data_q[lat_index];
        state_d          = StIdle;
      end
      StMemReq: begin
        cache_data_req = 1'b1;
        if (cache_data_addr_ok) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (cache_data_data_ok) begin
          cpu_data_data_ok = 1'b1;
          cpu_data_rdata   = cache_data_rdata;
          state_d          = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Reset silences every handshake, including one that lands mid-transaction.
    if (rst) begin
      state_d          = StIdle;
      cpu_data_addr_ok = 1'b0;
      cpu_data_data_ok = 1'b0;
      cpu_data_rdata   = '0;
      cache_data_req   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      nc_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else if (accept) begin
      wr_q    <= cpu_data_wr;
      size_q  <= cpu_data_size;
      addr_q  <= cpu_data_addr;
      wdata_q <= cpu_data_wdata;
      nc_q    <= no_dcache;
      hit_q   <= req_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[lat_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[lat_index]  <= lat_tag;
      data_q[lat_index] <= cache_data_rdata;
    end else if (merge_en) begin
      data_q[lat_index] <= merged_word;
    end
  end

endmodule
